// File: rtl/nibble_hex_uart_tx_pkg.sv
// Shared definitions for the nibble-to-hex UART transmitter.
//   - uart_state_e : UART FSM state encoding
//   - ASCII_ZERO / ASCII_A_MINUS10 : offsets for hex digit conversion
//   - nib2ascii    : maps a nibble to its uppercase ASCII hex character
package nibble_hex_uart_tx_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } uart_state_e;

   localparam logic [7:0] ASCII_ZERO      = 8'h30;
   // 'A' - 10, so that nibble 10 lands on 'A'
   localparam logic [7:0] ASCII_A_MINUS10 = 8'h37;

   function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return ASCII_ZERO + {4'h0, nib};
      end
      return ASCII_A_MINUS10 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/nibble_hex_uart_tx_fifo.sv
// Small nibble FIFO with wrap-bit pointers.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request and data (ignored when full unless popping too)
//   pop, rdata   : read request and head-of-queue data (valid when not empty)
//   full, empty  : occupancy flags
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module nibble_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [3:0] wdata,
   input  logic       pop,
   output logic [3:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [3:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   // Same index but different wrap bit means the writer has lapped the reader
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/nibble_hex_uart_tx.sv
// Captures changes on a 4-bit result bus, queues them and sends each as an
// ASCII hex character on an 8N1 UART line.
//   CLK    : system clock
//   RST    : asynchronous active-low reset
//   NIB_IN : nibble to observe (bit0 = O_0)
//   EN     : capture enable
//   TX     : UART serial output, idle high, registered
//   BUSY   : FSM active or characters still queued
//   OVF    : sticky, set when a capture was dropped on a full FIFO
module nibble_hex_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] NIB_IN,
   input  logic       EN,
   output logic       TX,
   output logic       BUSY,
   output logic       OVF
);

   import nibble_hex_uart_tx_pkg::*;

   localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   uart_state_e   state;
   logic [CW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tx_q;
   logic [3:0]    last;
   logic          primed;
   logic          ovf_q;

   logic          capture;
   logic          bit_end;
   logic          pop;
   logic [3:0]    fifo_head;
   logic          fifo_full;
   logic          fifo_empty;

   // Only new values are captured; the first capture after reset is unconditional
   assign capture = EN && (!primed || (NIB_IN != last));
   assign bit_end = (baud == BAUD_LAST);
   // Pop from IDLE, or at the very end of a stop bit for back-to-back frames
   assign pop     = !fifo_empty && ((state == StIdle) || ((state == StStop) && bit_end));

   nibble_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST),
      .push  (capture),
      .wdata (NIB_IN),
      .pop   (pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         last   <= 4'h0;
         primed <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (capture) begin
         // last/primed update even on a drop so the value is not retried
         last   <= NIB_IN;
         primed <= 1'b1;
         if (fifo_full && !pop) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= StIdle;
         baud    <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
         tx_q    <= 1'b1;
      end else begin
         unique case (state)
            StIdle: begin
               baud <= '0;
               tx_q <= 1'b1;
               if (pop) begin
                  shreg <= nib2ascii(fifo_head);
                  tx_q  <= 1'b0;
                  state <= StStart;
               end
            end
            StStart: begin
               if (bit_end) begin
                  baud    <= '0;
                  bit_idx <= 3'd0;
                  tx_q    <= shreg[0];
                  shreg   <= shreg >> 1;
                  state   <= StData;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            StData: begin
               if (bit_end) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     tx_q  <= 1'b1;
                     state <= StStop;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            StStop: begin
               if (bit_end) begin
                  baud <= '0;
                  if (pop) begin
                     shreg <= nib2ascii(fifo_head);
                     tx_q  <= 1'b0;
                     state <= StStart;
                  end else begin
                     state <= StIdle;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               state <= StIdle;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

   assign TX   = tx_q;
   assign OVF  = ovf_q;
   assign BUSY = (state != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_nibble_hex_uart_tx.sv
// Directed bench for nibble_hex_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A UART receiver process decodes every frame into a queue with its start cycle.
module tb_nibble_hex_uart_tx;

   logic       CLK    = 1'b0;
   logic       RST    = 1'b0;
   logic       EN     = 1'b1;
   logic [3:0] NIB_IN = 4'h3;
   logic       TX;
   logic       BUSY;
   logic       OVF;

   int total     = 0;
   int bad       = 0;
   int cyc       = 0;
   int frame_err = 0;

   logic [7:0] rx_q [$];
   int         rx_t [$];

   nibble_hex_uart_tx #(
      .CLKS_PER_BIT(4),
      .FIFO_DEPTH  (4)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .NIB_IN (NIB_IN),
      .EN     (EN),
      .TX     (TX),
      .BUSY   (BUSY),
      .OVF    (OVF)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Receiver: samples mid-bit on negedges, abandons a frame if reset is seen
   initial begin : rx
      logic [7:0] b;
      bit         ok;
      int         st;
      forever begin
         @(negedge CLK);
         if (RST && !TX) begin
            st = cyc;
            ok = 1'b1;
            b  = 8'h00;
            for (int i = 0; i < 10; i++) begin
               if (ok) begin
                  repeat ((i == 0) ? 2 : 4) @(negedge CLK);
                  if (!RST) ok = 1'b0;
                  else if (i == 0) begin
                     if (TX) frame_err++;
                  end else if (i == 9) begin
                     if (!TX) frame_err++;
                  end else b[i-1] = TX;
               end
            end
            if (ok) begin
               rx_q.push_back(b);
               rx_t.push_back(st);
            end
         end
      end
   end

   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge CLK);
         k++;
      end
      if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (BUSY && k < budget) begin
         @(negedge CLK);
         k++;
      end
      if (BUSY) check("idle_timeout", BUSY, 0);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_t.delete();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int c0;
      bit busy_seen;
      logic [7:0] exp6 [6];
      exp6 = '{8'h37, 8'h38, 8'h39, 8'h41, 8'h42, 8'h43};

      // 1: reset state, first frame latency and length
      repeat (3) @(negedge CLK);
      check("rst_tx", TX, 1);
      check("rst_busy", BUSY, 0);
      check("rst_ovf", OVF, 0);
      @(negedge CLK);
      c0  = cyc;
      RST = 1'b1;
      wait_rx(1, 100);
      check("t1_byte", rx_q[0], 8'h33);
      check("t1_latency", rx_t[0] - c0, 2);
      wait_idle(100);
      check("t1_frame_len", cyc - rx_t[0], 40);
      check("t1_tx_idle", TX, 1);

      // 2: held value sends exactly once
      clear_rx();
      @(negedge CLK);
      NIB_IN = 4'hA;
      repeat (200) @(negedge CLK);
      check("t2_count", rx_q.size(), 1);
      check("t2_byte", rx_q[0], 8'h41);
      check("t2_busy", BUSY, 0);

      // 3: burst overflows, queued frames go back-to-back
      clear_rx();
      check("t3_ovf_pre", OVF, 0);
      for (int v = 1; v <= 6; v++) begin
         @(negedge CLK);
         if (v == 1) c0 = cyc;
         NIB_IN = 4'(v);
      end
      @(negedge CLK);
      check("t3_ovf", OVF, 1);
      wait_rx(5, 400);
      wait_idle(100);
      check("t3_count", rx_q.size(), 5);
      check("t3_latency", rx_t[0] - c0, 2);
      for (int i = 0; i < 5; i++) check($sformatf("t3_byte%0d", i), rx_q[i], 8'h31 + i);
      for (int i = 0; i < 4; i++) check($sformatf("t3_gap%0d", i), rx_t[i+1] - rx_t[i], 40);

      // 4: reset mid-frame, then recapture of the unchanged value
      clear_rx();
      @(negedge CLK);
      NIB_IN = 4'h9;
      repeat (15) @(negedge CLK);
      check("t4_busy_pre", BUSY, 1);
      check("t4_tx_pre", TX, 0);
      #1 RST = 1'b0;
      #1;
      check("t4_rst_tx", TX, 1);
      check("t4_rst_busy", BUSY, 0);
      check("t4_rst_ovf", OVF, 0);
      repeat (5) @(negedge CLK);
      c0  = cyc;
      RST = 1'b1;
      wait_rx(1, 100);
      check("t4_byte", rx_q[0], 8'h39);
      check("t4_latency", rx_t[0] - c0, 2);
      wait_idle(100);
      check("t4_count", rx_q.size(), 1);

      // 5: EN=0 freezes capture; equal value after enable is not resent
      clear_rx();
      @(negedge CLK);
      NIB_IN = 4'hF;
      wait_rx(1, 100);
      wait_idle(100);
      check("t5_prime_byte", rx_q[0], 8'h46);
      EN        = 1'b0;
      busy_seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         NIB_IN = (i % 2 == 1) ? 4'h0 : 4'hF;
         if (BUSY) busy_seen = 1'b1;
      end
      @(negedge CLK);
      NIB_IN = 4'hF;
      EN     = 1'b1;
      repeat (60) @(negedge CLK);
      check("t5_busy_seen", busy_seen, 0);
      check("t5_count", rx_q.size(), 1);
      check("t5_busy", BUSY, 0);
      NIB_IN = 4'hE;
      wait_rx(2, 100);
      check("t5_byte", rx_q[1], 8'h45);
      wait_idle(100);

      // 6: push coincides with stop-end pop while FIFO is full
      clear_rx();
      check("t6_ovf_pre", OVF, 0);
      for (int v = 7; v <= 11; v++) begin
         @(negedge CLK);
         if (v == 7) c0 = cyc;
         NIB_IN = 4'(v);
      end
      repeat (37) @(negedge CLK);
      NIB_IN = 4'hC;
      repeat (2) @(negedge CLK);
      check("t6_ovf_mid", OVF, 0);
      wait_rx(6, 400);
      wait_idle(100);
      check("t6_count", rx_q.size(), 6);
      for (int i = 0; i < 6; i++) check($sformatf("t6_byte%0d", i), rx_q[i], exp6[i]);
      check("t6_latency", rx_t[0] - c0, 2);
      check("t6_ovf", OVF, 0);

      check("frame_err", frame_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nibble_hex_uart_tx.md
Name: nibble_hex_uart_tx

Overview:
Downstream consumer of the 4-bit O_0..O_3 result bus produced by the `main` circuit. It captures each new nibble value, buffers it in a small FIFO, and transmits it as an ASCII hex character ('0'-'9', 'A'-'F') over a single 8N1 UART line. The UART line drives one spare io_out pin so a host can log circuit activity without extra pins.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit; legal range >= 2.
FIFO_DEPTH, 4, nibble buffer entries; must be a power of 2, >= 2.

Ports:
CLK  input  1  system clock (io_in[0]).
RST  input  1  reset; asynchronous, active-low (io_in[1]).
NIB_IN  input  4  nibble from the main circuit; bit0 = O_0.
EN  input  1  capture enable; when 0, nothing is captured.
TX  output  1  UART serial out; idle high.
BUSY  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
OVF  output  1  sticky overflow flag: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (RST=0) acts asynchronously:
  - TX=1, BUSY=0, OVF=0.
  - FIFO emptied, FSM forced to IDLE.
  - `last` register cleared to 0; `primed` flag cleared to 0.
  - A frame in flight is abandoned; TX returns high immediately.
- Capture on each rising edge when EN=1 and (primed=0 or NIB_IN != last):
  - push NIB_IN into the FIFO;
  - last <= NIB_IN; primed <= 1.
  - `last` is updated only on a capture; EN=0 freezes it.
- FIFO full with a capture and no pop in the same cycle:
  - the nibble is dropped and OVF <= 1;
  - `last` and `primed` still update, so the same value is not retried.
- Simultaneous push and pop on a full FIFO: both happen, nothing is dropped, OVF is unchanged.
- ASCII mapping: 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46 (uppercase).
- FSM states and transitions:
  - IDLE: TX=1. If the FIFO is non-empty, pop the head, load the shift register with its ASCII code, and go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit index counts 0..7, then go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Latency: NIB_IN stable before edge N with a capture condition true -> FIFO written at edge N -> IDLE pops at edge N+1 -> TX low from edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- The baud counter is ceil(log2(CLKS_PER_BIT)) bits wide and resets to 0 on every bit boundary.
- TX is driven from a register (glitch-free).
- BUSY is combinational from state and FIFO count.
- No back-pressure exists toward the main circuit; dropped data is reported only through OVF.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - ASCII_ZERO=8'h30 and ASCII_A_MINUS10=8'h37;
  - the nib2ascii function.
- One sub-module, nibble_fifo (parameterised on FIFO_DEPTH):
  - push/pop/full/empty interface;
  - pointers with an extra wrap bit;
  - same-cycle push and pop allowed when full.
- Capture logic and the UART FSM live in the top module.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Release reset with EN=1, NIB_IN=0x3 -> one frame of 0x33: TX=0 for 4 cycles, then bits 1,1,0,0,1,1,0,0 at 4 cycles each, then stop=1 for 4 cycles. Total 40 cycles; BUSY falls after the stop bit.
2. Hold NIB_IN=0xA for 200 cycles with EN=1 -> exactly one frame (0x41); no repeat transmissions.
3. Apply NIB_IN=1,2,3,4,5,6 on consecutive edges -> '1' popped at the second edge and '2'-'5' buffered; 6 is dropped and OVF=1. Output frames are 0x31-0x35 in order, back-to-back with zero idle gap between stop and start.
4. Assert RST during the 3rd data bit of a frame -> TX=1, BUSY=0, OVF=0 within the same cycle. Release RST with NIB_IN unchanged and EN=1 -> the value is recaptured (primed cleared) and a full new frame is sent.
5. Set EN=0 while NIB_IN toggles 0xF/0x0 for 50 cycles -> no frames and BUSY=0. Then set EN=1 with NIB_IN=0xF and last=0xF -> no capture; change NIB_IN to 0xE -> frame 0x45.
6. Push and pop on the same edge with the FIFO full (stop-bit end coincides with a new nibble) -> no drop, OVF stays 0, and all queued characters are emitted.
